// File: rtl/rs_alu_pkg.sv
// Shared definitions for the ALU reservation station: bus widths, default depth
// and the decoded instruction codes (NOP is code 0).
package rs_alu_pkg;

    localparam int RS_SIZE_DEF = 16;
    localparam int INST_W      = 6;
    localparam int TAG_W       = 4;
    localparam int XLEN        = 32;

    typedef enum logic [INST_W-1:0] {
        INST_NOP = 6'd0,
        INST_LUI, INST_AUIPC, INST_JAL, INST_JALR,
        INST_BEQ, INST_BNE, INST_BLT, INST_BGE, INST_BLTU, INST_BGEU,
        INST_ADDI, INST_SLTI, INST_SLTIU, INST_XORI, INST_ORI, INST_ANDI,
        INST_SLLI, INST_SRLI, INST_SRAI,
        INST_ADD, INST_SUB, INST_SLL, INST_SLT, INST_SLTU,
        INST_XOR, INST_SRL, INST_SRA, INST_OR, INST_AND
    } inst_e;

endpackage

// File: rtl/rs_alu_select.sv
// Lowest-index priority encoder: reports whether any request bit is set and
// the index of the lowest one.
module rs_select
    import rs_alu_pkg::*;
#(
    parameter int N     = RS_SIZE_DEF,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (req[i] && !found) begin
                found = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/rs_alu.sv
// ALU reservation station: buffers dispatched ops until both operands are ready,
// snoops the ALU/LSB CDBs, and issues one ready op per cycle from registered outputs.
module rs_alu
    import rs_alu_pkg::*;
#(
    parameter int RS_SIZE = RS_SIZE_DEF,
    parameter int INST_W  = rs_alu_pkg::INST_W,
    parameter int TAG_W   = rs_alu_pkg::TAG_W,
    parameter int XLEN    = rs_alu_pkg::XLEN
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              flush_in,
    input  logic              disp_valid,
    input  logic [INST_W-1:0] disp_inst,
    input  logic [XLEN-1:0]   disp_npc,
    input  logic [XLEN-1:0]   disp_imme,
    input  logic              disp_rs1_rdy,
    input  logic [XLEN-1:0]   disp_rs1_val,
    input  logic [TAG_W-1:0]  disp_rs1_tag,
    input  logic              disp_rs2_rdy,
    input  logic [XLEN-1:0]   disp_rs2_val,
    input  logic [TAG_W-1:0]  disp_rs2_tag,
    input  logic [TAG_W-1:0]  disp_dest_tag,
    output logic              rs_full,
    input  logic              cdb_alu_valid,
    input  logic [TAG_W-1:0]  cdb_alu_tag,
    input  logic [XLEN-1:0]   cdb_alu_val,
    input  logic              cdb_lsb_valid,
    input  logic [TAG_W-1:0]  cdb_lsb_tag,
    input  logic [XLEN-1:0]   cdb_lsb_val,
    output logic              out_valid,
    output logic [INST_W-1:0] out_inst,
    output logic [XLEN-1:0]   out_npc,
    output logic [XLEN-1:0]   out_imme,
    output logic [XLEN-1:0]   out_rs1_val,
    output logic [XLEN-1:0]   out_rs2_val,
    output logic [TAG_W-1:0]  out_tag
);

    localparam int IDX_W = $clog2(RS_SIZE);
    localparam int CNT_W = IDX_W + 1;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [XLEN-1:0]   npc;
        logic [XLEN-1:0]   imme;
        logic [TAG_W-1:0]  dest;
        logic [TAG_W-1:0]  tag1;
        logic [XLEN-1:0]   val1;
        logic [TAG_W-1:0]  tag2;
        logic [XLEN-1:0]   val2;
    } entry_t;

    entry_t             ent [RS_SIZE];
    logic [RS_SIZE-1:0] busy, rdy1, rdy2;
    logic [CNT_W-1:0]   count;

    logic             free_found, iss_found;
    logic [IDX_W-1:0] free_idx, iss_idx;
    logic             disp_ok;
    logic             d_rdy1, d_rdy2;
    logic [XLEN-1:0]  d_val1, d_val2;

    rs_select #(.N(RS_SIZE), .IDX_W(IDX_W)) u_free_sel (
        .req   (~busy),
        .found (free_found),
        .idx   (free_idx)
    );

    rs_select #(.N(RS_SIZE), .IDX_W(IDX_W)) u_issue_sel (
        .req   (busy & rdy1 & rdy2),
        .found (iss_found),
        .idx   (iss_idx)
    );

    assign rs_full = (count == CNT_W'(RS_SIZE));
    assign disp_ok = disp_valid && !rs_full && free_found;

    // Same-cycle CDB bypass for the dispatched op; ALU bus wins on a tag clash.
    always_comb begin
        d_rdy1 = disp_rs1_rdy;
        d_val1 = disp_rs1_val;
        d_rdy2 = disp_rs2_rdy;
        d_val2 = disp_rs2_val;
        if (!disp_rs1_rdy) begin
            if (cdb_alu_valid && cdb_alu_tag == disp_rs1_tag) begin
                d_rdy1 = 1'b1;
                d_val1 = cdb_alu_val;
            end else if (cdb_lsb_valid && cdb_lsb_tag == disp_rs1_tag) begin
                d_rdy1 = 1'b1;
                d_val1 = cdb_lsb_val;
            end
        end
        if (!disp_rs2_rdy) begin
            if (cdb_alu_valid && cdb_alu_tag == disp_rs2_tag) begin
                d_rdy2 = 1'b1;
                d_val2 = cdb_alu_val;
            end else if (cdb_lsb_valid && cdb_lsb_tag == disp_rs2_tag) begin
                d_rdy2 = 1'b1;
                d_val2 = cdb_lsb_val;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            busy        <= '0;
            rdy1        <= '0;
            rdy2        <= '0;
            count       <= '0;
            out_valid   <= 1'b0;
            out_inst    <= '0;
            out_npc     <= '0;
            out_imme    <= '0;
            out_rs1_val <= '0;
            out_rs2_val <= '0;
            out_tag     <= '0;
            for (int unsigned i = 0; i < RS_SIZE; i++) ent[i] <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                busy        <= '0;
                rdy1        <= '0;
                rdy2        <= '0;
                count       <= '0;
                out_valid   <= 1'b0;
                out_inst    <= '0;
                out_npc     <= '0;
                out_imme    <= '0;
                out_rs1_val <= '0;
                out_rs2_val <= '0;
                out_tag     <= '0;
            end else begin
                if (iss_found) begin
                    out_valid      <= 1'b1;
                    out_inst       <= ent[iss_idx].inst;
                    out_npc        <= ent[iss_idx].npc;
                    out_imme       <= ent[iss_idx].imme;
                    out_rs1_val    <= ent[iss_idx].val1;
                    out_rs2_val    <= ent[iss_idx].val2;
                    out_tag        <= ent[iss_idx].dest;
                    busy[iss_idx]  <= 1'b0;
                end else begin
                    out_valid   <= 1'b0;
                    out_inst    <= '0;
                    out_npc     <= '0;
                    out_imme    <= '0;
                    out_rs1_val <= '0;
                    out_rs2_val <= '0;
                    out_tag     <= '0;
                end

                for (int unsigned i = 0; i < RS_SIZE; i++) begin
                    if (busy[i] && !rdy1[i]) begin
                        if (cdb_alu_valid && cdb_alu_tag == ent[i].tag1) begin
                            rdy1[i]     <= 1'b1;
                            ent[i].val1 <= cdb_alu_val;
                        end else if (cdb_lsb_valid && cdb_lsb_tag == ent[i].tag1) begin
                            rdy1[i]     <= 1'b1;
                            ent[i].val1 <= cdb_lsb_val;
                        end
                    end
                    if (busy[i] && !rdy2[i]) begin
                        if (cdb_alu_valid && cdb_alu_tag == ent[i].tag2) begin
                            rdy2[i]     <= 1'b1;
                            ent[i].val2 <= cdb_alu_val;
                        end else if (cdb_lsb_valid && cdb_lsb_tag == ent[i].tag2) begin
                            rdy2[i]     <= 1'b1;
                            ent[i].val2 <= cdb_lsb_val;
                        end
                    end
                end

                // Free slot is never busy, so it cannot collide with issue or wake-up writes.
                if (disp_ok) begin
                    busy[free_idx] <= 1'b1;
                    rdy1[free_idx] <= d_rdy1;
                    rdy2[free_idx] <= d_rdy2;
                    ent[free_idx]  <= '{inst: disp_inst, npc: disp_npc, imme: disp_imme,
                                        dest: disp_dest_tag, tag1: disp_rs1_tag, val1: d_val1,
                                        tag2: disp_rs2_tag, val2: d_val2};
                end

                count <= count + CNT_W'(disp_ok) - CNT_W'(iss_found);
            end
        end
    end

endmodule

// File: tb/tb_rs_alu.sv
// Self-checking bench for rs_alu: directed scenarios followed by random traffic,
// all compared against a cycle-level behavioural model of the reservation station.
module tb_rs_alu;
    import rs_alu_pkg::*;

    localparam int N = 16;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, flush_in;
    logic        disp_valid;
    logic [5:0]  disp_inst;
    logic [31:0] disp_npc, disp_imme;
    logic        disp_rs1_rdy, disp_rs2_rdy;
    logic [31:0] disp_rs1_val, disp_rs2_val;
    logic [3:0]  disp_rs1_tag, disp_rs2_tag, disp_dest_tag;
    logic        rs_full;
    logic        cdb_alu_valid, cdb_lsb_valid;
    logic [3:0]  cdb_alu_tag, cdb_lsb_tag;
    logic [31:0] cdb_alu_val, cdb_lsb_val;
    logic        out_valid;
    logic [5:0]  out_inst;
    logic [31:0] out_npc, out_imme, out_rs1_val, out_rs2_val;
    logic [3:0]  out_tag;

    always #5 clk_in = ~clk_in;

    rs_alu #(.RS_SIZE(N), .INST_W(6), .TAG_W(4), .XLEN(32)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .disp_valid(disp_valid), .disp_inst(disp_inst), .disp_npc(disp_npc),
        .disp_imme(disp_imme), .disp_rs1_rdy(disp_rs1_rdy), .disp_rs1_val(disp_rs1_val),
        .disp_rs1_tag(disp_rs1_tag), .disp_rs2_rdy(disp_rs2_rdy), .disp_rs2_val(disp_rs2_val),
        .disp_rs2_tag(disp_rs2_tag), .disp_dest_tag(disp_dest_tag), .rs_full(rs_full),
        .cdb_alu_valid(cdb_alu_valid), .cdb_alu_tag(cdb_alu_tag), .cdb_alu_val(cdb_alu_val),
        .cdb_lsb_valid(cdb_lsb_valid), .cdb_lsb_tag(cdb_lsb_tag), .cdb_lsb_val(cdb_lsb_val),
        .out_valid(out_valid), .out_inst(out_inst), .out_npc(out_npc), .out_imme(out_imme),
        .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val), .out_tag(out_tag)
    );

    typedef struct {
        bit          busy;
        logic [5:0]  inst;
        logic [31:0] npc, imme;
        logic [3:0]  dest;
        logic        r1, r2;
        logic [31:0] v1, v2;
        logic [3:0]  t1, t2;
    } ment_t;

    ment_t       m [N];
    logic        e_valid;
    logic [5:0]  e_inst;
    logic [31:0] e_npc, e_imme, e_v1, e_v2;
    logic [3:0]  e_tag;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void clear_expected();
        e_valid = 1'b0; e_inst = '0; e_npc = '0; e_imme = '0;
        e_v1 = '0; e_v2 = '0; e_tag = '0;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N; i++) m[i].busy = 0;
        clear_expected();
    endfunction

    function automatic int occupancy();
        int n = 0;
        for (int i = 0; i < N; i++) if (m[i].busy) n++;
        return n;
    endfunction

    // Applies the CDB snoop rule to one source operand: {ready, value}.
    function automatic logic [32:0] snoop(input logic r, input logic [31:0] v, input logic [3:0] t);
        if (r) return {1'b1, v};
        if (cdb_alu_valid && cdb_alu_tag == t) return {1'b1, cdb_alu_val};
        if (cdb_lsb_valid && cdb_lsb_tag == t) return {1'b1, cdb_lsb_val};
        return {1'b0, v};
    endfunction

    // One clock edge worth of behaviour, computed from the state at the start of the cycle.
    function automatic void model_step();
        int    cand, slot, occ;
        ment_t nm [N];
        ment_t d;
        if (!rdy_in) return;
        if (flush_in) begin
            model_reset();
            return;
        end
        occ = occupancy();
        cand = -1;
        slot = -1;
        for (int i = 0; i < N; i++) begin
            if (cand < 0 && m[i].busy && m[i].r1 && m[i].r2) cand = i;
            if (slot < 0 && !m[i].busy) slot = i;
        end
        nm = m;
        if (cand >= 0) begin
            e_valid = 1'b1; e_inst = m[cand].inst; e_npc = m[cand].npc;
            e_imme = m[cand].imme; e_v1 = m[cand].v1; e_v2 = m[cand].v2; e_tag = m[cand].dest;
            nm[cand].busy = 0;
        end else begin
            clear_expected();
        end
        for (int i = 0; i < N; i++) begin
            if (m[i].busy && i != cand) begin
                {nm[i].r1, nm[i].v1} = snoop(m[i].r1, m[i].v1, m[i].t1);
                {nm[i].r2, nm[i].v2} = snoop(m[i].r2, m[i].v2, m[i].t2);
            end
        end
        if (disp_valid && occ < N) begin
            d.busy = 1; d.inst = disp_inst; d.npc = disp_npc; d.imme = disp_imme;
            d.dest = disp_dest_tag; d.t1 = disp_rs1_tag; d.t2 = disp_rs2_tag;
            {d.r1, d.v1} = snoop(disp_rs1_rdy, disp_rs1_val, disp_rs1_tag);
            {d.r2, d.v2} = snoop(disp_rs2_rdy, disp_rs2_val, disp_rs2_tag);
            nm[slot] = d;
        end
        m = nm;
    endfunction

    task automatic compare_all();
        check("out_valid", 32'(out_valid), 32'(e_valid));
        check("out_inst", 32'(out_inst), 32'(e_inst));
        check("out_npc", out_npc, e_npc);
        check("out_imme", out_imme, e_imme);
        check("out_rs1_val", out_rs1_val, e_v1);
        check("out_rs2_val", out_rs2_val, e_v2);
        check("out_tag", 32'(out_tag), 32'(e_tag));
        check("rs_full", 32'(rs_full), 32'(occupancy() == N));
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk_in);
        #1;
        compare_all();
    endtask

    task automatic idle();
        disp_valid = 0; cdb_alu_valid = 0; cdb_lsb_valid = 0; flush_in = 0;
    endtask

    task automatic disp_op(input logic [5:0] inst, input logic [31:0] npc, input logic [31:0] imme,
                           input logic r1, input logic [31:0] v1, input logic [3:0] t1,
                           input logic r2, input logic [31:0] v2, input logic [3:0] t2,
                           input logic [3:0] dest);
        disp_valid = 1; disp_inst = inst; disp_npc = npc; disp_imme = imme;
        disp_rs1_rdy = r1; disp_rs1_val = v1; disp_rs1_tag = t1;
        disp_rs2_rdy = r2; disp_rs2_val = v2; disp_rs2_tag = t2; disp_dest_tag = dest;
    endtask

    task automatic alu_bc(input logic [3:0] t, input logic [31:0] v);
        cdb_alu_valid = 1; cdb_alu_tag = t; cdb_alu_val = v;
    endtask

    task automatic lsb_bc(input logic [3:0] t, input logic [31:0] v);
        cdb_lsb_valid = 1; cdb_lsb_tag = t; cdb_lsb_val = v;
    endtask

    initial begin
        rst_in = 0; rdy_in = 1;
        idle();
        disp_inst = '0; disp_npc = '0; disp_imme = '0;
        disp_rs1_rdy = 0; disp_rs1_val = '0; disp_rs1_tag = '0;
        disp_rs2_rdy = 0; disp_rs2_val = '0; disp_rs2_tag = '0; disp_dest_tag = '0;
        cdb_alu_tag = '0; cdb_alu_val = '0; cdb_lsb_tag = '0; cdb_lsb_val = '0;
        model_reset();
        #12;
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_full", 32'(rs_full), 32'd0);
        check("reset_inst", 32'(out_inst), 32'd0);
        @(negedge clk_in);
        rst_in = 1;

        // Basic issue: ready addi goes out one edge after it is stored.
        disp_op(INST_ADDI, 32'h104, 32'd7, 1, 32'd5, 4'd0, 1, 32'd0, 4'd0, 4'd3);
        cycle();
        check("t1_no_issue_yet", 32'(out_valid), 32'd0);
        idle();
        cycle();
        check("t1_valid", 32'(out_valid), 32'd1);
        check("t1_inst", 32'(out_inst), 32'(INST_ADDI));
        check("t1_rs1", out_rs1_val, 32'd5);
        check("t1_imme", out_imme, 32'd7);
        check("t1_tag", 32'(out_tag), 32'd3);
        cycle();
        check("t1_drain", 32'(out_valid), 32'd0);

        // Wake-up over the ALU bus, then over the LSB bus.
        disp_op(INST_ADD, 32'h200, 32'd0, 0, 32'd0, 4'd2, 1, 32'd1, 4'd0, 4'd4);
        cycle();
        idle();
        cycle();
        alu_bc(4'd2, 32'h10);
        cycle();
        check("wake_alu_not_same", 32'(out_valid), 32'd0);
        idle();
        cycle();
        check("wake_alu_valid", 32'(out_valid), 32'd1);
        check("wake_alu_rs1", out_rs1_val, 32'h10);
        disp_op(INST_SUB, 32'h300, 32'd0, 0, 32'd0, 4'd5, 1, 32'd2, 4'd0, 4'd6);
        cycle();
        idle();
        lsb_bc(4'd5, 32'h20);
        cycle();
        idle();
        cycle();
        check("wake_lsb_rs1", out_rs1_val, 32'h20);

        // Dispatch-cycle bypass on rs2.
        disp_op(INST_XOR, 32'h400, 32'd0, 1, 32'd3, 4'd0, 0, 32'd0, 4'd6, 4'd7);
        lsb_bc(4'd6, 32'hFF);
        cycle();
        idle();
        cycle();
        check("bypass_valid", 32'(out_valid), 32'd1);
        check("bypass_rs2", out_rs2_val, 32'hFF);
        cycle();

        // Fill all entries, entry i blocked on tag i.
        for (int i = 0; i < N; i++) begin
            disp_op(INST_OR, 32'h1000 + 32'(i * 4), 32'(i), 0, 32'd0, 4'(i), 1, 32'hAA, 4'd0, 4'(i));
            cycle();
        end
        check("fill_full", 32'(rs_full), 32'd1);
        disp_op(INST_AND, 32'h5000, 32'd0, 1, 32'd0, 4'd0, 1, 32'd0, 4'd0, 4'd1);
        cycle();
        idle();
        alu_bc(4'd9, 32'h99);
        cycle();
        idle();
        cycle();
        check("single_wake_tag", 32'(out_tag), 32'd9);
        check("single_wake_npc", out_npc, 32'h1024);
        check("single_wake_notfull", 32'(rs_full), 32'd0);
        disp_op(INST_ADDI, 32'h2000, 32'd1, 1, 32'd1, 4'd0, 1, 32'd1, 4'd0, 4'd9);
        alu_bc(4'd10, 32'hA0);
        cycle();
        idle();
        cycle();
        check("refill_slot_first", out_npc, 32'h2000);
        cycle();
        check("refill_then_e10", out_npc, 32'h1028);
        alu_bc(4'd12, 32'hC0);
        lsb_bc(4'd3, 32'h30);
        cycle();
        idle();
        cycle();
        check("order_low_first", out_npc, 32'h100C);
        cycle();
        check("order_high_next", out_npc, 32'h1030);

        // Flush with 5 occupied entries and a dispatch in the flush cycle.
        flush_in = 1;
        cycle();
        idle();
        for (int i = 1; i <= 5; i++) begin
            disp_op(INST_SLT, 32'h6000 + 32'(i), 32'd0, 0, 32'd0, 4'(i), 1, 32'd0, 4'd0, 4'(i));
            cycle();
        end
        disp_op(INST_ADD, 32'h7000, 32'd0, 1, 32'd0, 4'd0, 1, 32'd0, 4'd0, 4'd0);
        flush_in = 1;
        cycle();
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_full", 32'(rs_full), 32'd0);
        idle();
        for (int i = 0; i < N; i++) begin
            alu_bc(4'(i), 32'hDEAD);
            cycle();
            check("flush_no_issue", 32'(out_valid), 32'd0);
        end
        idle();

        // Freeze with rdy_in low.
        disp_op(INST_SRL, 32'h8000, 32'd0, 0, 32'd0, 4'd7, 1, 32'd0, 4'd0, 4'd2);
        cycle();
        disp_op(INST_SLL, 32'h3000, 32'd0, 1, 32'd1, 4'd0, 1, 32'd2, 4'd0, 4'd1);
        cycle();
        idle();
        rdy_in = 0;
        alu_bc(4'd7, 32'h77);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("freeze_no_issue", 32'(out_valid), 32'd0);
        end
        idle();
        rdy_in = 1;
        cycle();
        check("unfreeze_issue", out_npc, 32'h3000);
        cycle();
        check("freeze_no_capture", 32'(out_valid), 32'd0);
        alu_bc(4'd7, 32'h78);
        cycle();
        idle();
        cycle();
        check("late_capture", out_rs1_val, 32'h78);

        // Asynchronous reset between edges, with rdy_in low.
        rdy_in = 0;
        #2;
        rst_in = 0;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_rs1", out_rs1_val, 32'd0);
        check("async_rst_npc", out_npc, 32'd0);
        model_reset();
        @(negedge clk_in);
        rst_in = 1;
        rdy_in = 1;

        // Random traffic.
        for (int c = 0; c < 600; c++) begin
            rdy_in        = ($urandom_range(0, 9) != 0);
            flush_in      = ($urandom_range(0, 39) == 0);
            disp_valid    = $urandom_range(0, 1);
            disp_inst     = 6'($urandom_range(1, 30));
            disp_npc      = $urandom;
            disp_imme     = $urandom;
            disp_rs1_rdy  = ($urandom_range(0, 2) == 0);
            disp_rs1_val  = $urandom;
            disp_rs1_tag  = 4'($urandom);
            disp_rs2_rdy  = ($urandom_range(0, 2) == 0);
            disp_rs2_val  = $urandom;
            disp_rs2_tag  = 4'($urandom);
            disp_dest_tag = 4'($urandom);
            cdb_alu_valid = ($urandom_range(0, 4) < 2);
            cdb_alu_tag   = 4'($urandom);
            cdb_alu_val   = $urandom;
            cdb_lsb_valid = ($urandom_range(0, 4) < 2);
            cdb_lsb_tag   = 4'($urandom);
            cdb_lsb_val   = $urandom;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
